// File: rtl/scan_seq_misr_if.sv
// Scan sequencer bus: run control, status, signature and the four scan pins.
// The master side is the sequencer; the slave side is whatever drives the run
// controls and closes the scan loop through the core.
interface scan_seq_misr_if #(
  parameter int PRPG_W = 16,
  parameter int MISR_W = 16
);
  logic              start;
  logic [15:0]       num_patterns;
  logic [PRPG_W-1:0] seed;
  logic              test_mode;
  logic              test_se;
  logic              test_si;
  logic              test_so;
  logic              busy;
  logic              done;
  logic [MISR_W-1:0] signature;

  modport master (
    input  start, num_patterns, seed, test_so,
    output test_mode, test_se, test_si, busy, done, signature
  );

  modport slave (
    output start, num_patterns, seed, test_so,
    input  test_mode, test_se, test_si, busy, done, signature
  );
endinterface

// File: rtl/scan_seq_misr.sv
// On-chip scan-test sequencer. A Galois PRPG feeds the load patterns into
// test_si, shift and launch/capture windows are driven on test_se, and the
// unloaded test_so stream is compressed into a Galois MISR whose contents
// are presented as the run signature.
module scan_seq_misr #(
  parameter int                CHAIN_LEN      = 64,
  parameter int                CAPTURE_CYCLES = 2,
  parameter int                PRPG_W         = 16,
  parameter logic [PRPG_W-1:0] PRPG_POLY      = 16'hB400,
  parameter int                MISR_W         = 16,
  parameter logic [MISR_W-1:0] MISR_POLY      = 16'h100B
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  scan_seq_misr_if.master        bus
);

  localparam int CNT_MAX = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PRPG_W-1:0] prpg, prpg_n;
  logic [MISR_W-1:0] misr, misr_n;
  logic [15:0]       pat_cnt, pat_cnt_n;
  logic [15:0]       npat, npat_n;
  logic              first, first_n;
  logic              busy_r, busy_n;
  logic              se_r, se_n;
  logic              si_r, si_n;
  logic              done_r, done_n;

  // One right-shift step of the Galois pattern generator.
  function automatic logic [PRPG_W-1:0] prpg_step(input logic [PRPG_W-1:0] p);
    return (p >> 1) ^ (p[0] ? PRPG_POLY : '0);
  endfunction

  // One left-shift step of the signature register, absorbing one scan-out bit.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] m,
                                                  input logic              d);
    logic [MISR_W-1:0] n;
    n    = (m << 1) ^ (m[MISR_W-1] ? MISR_POLY : '0);
    n[0] = n[0] ^ d;
    return n;
  endfunction

  // Next-state, datapath update and next values of the registered outputs.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    prpg_n    = prpg;
    misr_n    = misr;
    pat_cnt_n = pat_cnt;
    npat_n    = npat;
    first_n   = first;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          npat_n    = bus.num_patterns;
          prpg_n    = (bus.seed == '0) ? PRPG_W'(1) : bus.seed;
          misr_n    = '0;
          pat_cnt_n = '0;
          first_n   = 1'b1;
          cnt_n     = '0;
          state_n   = (bus.num_patterns != 16'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        prpg_n = prpg_step(prpg);
        // The chain holds no valid response until the first pattern is in.
        if (!first) misr_n = misr_step(misr, bus.test_so);
        if (cnt == SHIFT_LAST) begin
          cnt_n   = '0;
          first_n = 1'b0;
          state_n = CAPTURE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        if (cnt == CAP_LAST) begin
          cnt_n     = '0;
          pat_cnt_n = pat_cnt + 16'd1;
          // Unload of the last pattern needs a pure flush; otherwise the
          // unload overlaps the next load.
          state_n   = (pat_cnt + 16'd1 == npat) ? FLUSH : SHIFT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      FLUSH: begin
        misr_n = misr_step(misr, bus.test_so);
        if (cnt == SHIFT_LAST) begin
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    busy_n = (state_n != IDLE);
    se_n   = (state_n == SHIFT) || (state_n == FLUSH);
    si_n   = (state_n == SHIFT) ? prpg_n[0] : 1'b0;
    done_n = (state_n == DONE);
  end

  // State, datapath and output registers; reset aborts any run in progress.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      prpg    <= PRPG_W'(1);
      misr    <= '0;
      pat_cnt <= '0;
      npat    <= '0;
      first   <= 1'b0;
      busy_r  <= 1'b0;
      se_r    <= 1'b0;
      si_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      prpg    <= prpg_n;
      misr    <= misr_n;
      pat_cnt <= pat_cnt_n;
      npat    <= npat_n;
      first   <= first_n;
      busy_r  <= busy_n;
      se_r    <= se_n;
      si_r    <= si_n;
      done_r  <= done_n;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.test_mode = busy_r;
  assign bus.test_se   = se_r;
  assign bus.test_si   = si_r;
  assign bus.done      = done_r;
  assign bus.signature = misr;

endmodule
